// File: rtl/pic_stat_pkg.sv
// rtl/pic_stat_pkg.sv - shared types, encodings and pixel scaling for the picture statistics engine
package pic_stat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    DONE
  } state_t;

  localparam logic [1:0] RATIO_QUARTER = 2'd0;
  localparam logic [1:0] RATIO_HALF    = 2'd1;
  localparam logic [1:0] RATIO_UNITY   = 2'd2;
  localparam logic [1:0] RATIO_DOUBLE  = 2'd3;

  localparam logic MODE_MEAN     = 1'b0;
  localparam logic MODE_CONTRAST = 1'b1;

  // Exposure scaling; the doubling case saturates so the mean never exceeds 255.
  function automatic logic [7:0] scale_pix(input logic [7:0] p, input logic [1:0] ratio);
    logic [8:0] dbl;
    dbl = {p, 1'b0};
    case (ratio)
      RATIO_QUARTER: scale_pix = {2'b00, p[7:2]};
      RATIO_HALF:    scale_pix = {1'b0, p[7:1]};
      RATIO_UNITY:   scale_pix = p;
      default:       scale_pix = dbl[8] ? 8'hFF : dbl[7:0];
    endcase
  endfunction

endpackage

// File: rtl/pic_stat_acc.sv
// rtl/pic_stat_acc.sv - per-picture accumulator, previous-pixel register and beat counter
module pic_stat_acc #(
  parameter int PIC_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       mode,
  input  logic [1:0] ratio,
  input  logic [7:0] pix,
  output logic [7:0] result,
  output logic       last
);
  import pic_stat_pkg::*;

  localparam int LOG2  = $clog2(PIC_BYTES);
  localparam int ACC_W = 8 + LOG2;
  localparam logic [LOG2-1:0] LAST_CNT = LOG2'(PIC_BYTES - 1);

  logic [ACC_W-1:0] acc;
  logic [7:0]       prev;
  logic [LOG2-1:0]  cnt;
  logic [7:0]       diff;
  logic [7:0]       term;

  always_comb begin
    diff = (pix >= prev) ? (pix - prev) : (prev - pix);
    term = 8'd0;
    if (mode == MODE_MEAN) begin
      term = scale_pix(pix, ratio);
    end else if (cnt != '0) begin
      term = diff;
    end
  end

  // Beat 0 of a contrast picture only seeds prev; term is forced to zero above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      prev <= '0;
      cnt  <= '0;
    end else if (clr) begin
      acc  <= '0;
      prev <= '0;
      cnt  <= '0;
    end else if (en) begin
      acc  <= acc + ACC_W'(term);
      prev <= pix;
      cnt  <= cnt + 1'b1;
    end
  end

  assign last   = en && (cnt == LAST_CNT);
  assign result = acc[ACC_W-1:LOG2];

endmodule

// File: rtl/pic_stat_engine.sv
// rtl/pic_stat_engine.sv - command-driven picture statistics engine; optional result cache via PIC_STAT_CACHE_EN
module pic_stat_engine #(
  parameter int PIC_BYTES = 16,
  parameter int PIC_CNT   = 16,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        in_pic_no,
  input  logic              in_mode,
  input  logic [1:0]        in_ratio_mode,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_data_valid,
  input  logic [7:0]        rd_data,
  output logic              out_valid,
  output logic [7:0]        out_data
);
  import pic_stat_pkg::*;

  localparam int LOG2 = $clog2(PIC_BYTES);

  state_t            state, state_nx;
  logic [3:0]        pic_q;
  logic              mode_q;
  logic [1:0]        ratio_q;
  logic              accept;
  logic              beat;
  logic              last;
  logic              hit;
  logic [7:0]        acc_result;
  logic [7:0]        result;
  logic [ADDR_W-1:0] base_addr;

  assign accept    = (state == IDLE) && in_valid;
  assign beat      = (state == RECV) && rd_data_valid;
  assign base_addr = ADDR_W'(pic_q) << LOG2;

  pic_stat_acc #(
    .PIC_BYTES(PIC_BYTES)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (beat),
    .mode  (mode_q),
    .ratio (ratio_q),
    .pix   (rd_data),
    .result(acc_result),
    .last  (last)
  );

`ifdef PIC_STAT_CACHE_EN
  logic [PIC_CNT-1:0] cache_vld;
  logic [2:0]         cache_tag [PIC_CNT];
  logic [7:0]         cache_res [PIC_CNT];
  logic               hit_q;
  logic [7:0]         hit_res_q;

  assign hit = cache_vld[in_pic_no] && (cache_tag[in_pic_no] == {in_mode, in_ratio_mode});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= '0;
      hit_q     <= 1'b0;
      hit_res_q <= '0;
    end else begin
      if (accept) begin
        hit_q     <= hit;
        hit_res_q <= cache_res[in_pic_no];
      end
      if ((state == DONE) && !hit_q) begin
        cache_vld[pic_q] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if ((state == DONE) && !hit_q) begin
      cache_tag[pic_q] <= {mode_q, ratio_q};
      cache_res[pic_q] <= acc_result;
    end
  end

  assign result = hit_q ? hit_res_q : acc_result;
`else
  assign hit    = 1'b0;
  assign result = acc_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = hit ? DONE : REQ;
        end
      end
      REQ: begin
        rd_req_valid = 1'b1;
        rd_req_addr  = base_addr;
        if (rd_req_ready) begin
          state_nx = RECV;
        end
      end
      RECV: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pic_q   <= '0;
      mode_q  <= MODE_MEAN;
      ratio_q <= RATIO_QUARTER;
    end else if (accept) begin
      pic_q   <= in_pic_no;
      mode_q  <= in_mode;
      ratio_q <= in_ratio_mode;
    end
  end

  // Result leaves through a register so out_data is zero outside the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (state == DONE);
      out_data  <= (state == DONE) ? result : 8'd0;
    end
  end

endmodule

// File: tb/tb_pic_stat_engine.sv
// tb/tb_pic_stat_engine.sv - directed table-driven bench for pic_stat_engine with a behavioural DRAM
module tb_pic_stat_engine;

  localparam int PIC_BYTES = 16;
  localparam int PIC_CNT   = 16;
  localparam int ADDR_W    = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [3:0]        in_pic_no;
  logic              in_mode;
  logic [1:0]        in_ratio_mode;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_data_valid;
  logic [7:0]        rd_data;
  logic              out_valid;
  logic [7:0]        out_data;

  typedef struct {
    logic [3:0]  pic;
    logic        mode;
    logic [1:0]  ratio;
    int          delay;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t       vecs [12];
  vec_t       v_tmp;
  logic [7:0] mem [PIC_CNT*PIC_BYTES];
  int         n_vec = 0;
  int         n_err = 0;

  pic_stat_engine #(
    .PIC_BYTES(PIC_BYTES),
    .PIC_CNT  (PIC_CNT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_pic_no    (in_pic_no),
    .in_mode      (in_mode),
    .in_ratio_mode(in_ratio_mode),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data),
    .out_valid    (out_valid),
    .out_data     (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command in the current cycle and plays the DRAM side to completion.
  task automatic run_vec(input vec_t v, input bit inject);
    int cyc;
    int early;
    int k;
    bit seen;
    early         = 0;
    in_valid      = 1'b1;
    in_pic_no     = v.pic;
    in_mode       = v.mode;
    in_ratio_mode = v.ratio;
    tick();
    in_valid = 1'b0;
    cyc      = 1;
    chk("req_valid", rd_req_valid, 1);
    chk("req_addr", rd_req_addr, v.addr);
    for (int d = 0; d < v.delay; d++) begin
      rd_req_ready = 1'b0;
      tick();
      cyc++;
      chk("req_hold_valid", rd_req_valid, 1);
      chk("req_hold_addr", rd_req_addr, v.addr);
    end
    rd_req_ready = 1'b1;
    tick();
    cyc++;
    rd_req_ready = 1'b0;
    chk("req_drop", rd_req_valid, 0);
    for (int b = 0; b < PIC_BYTES; b++) begin
      rd_data_valid = 1'b1;
      rd_data       = mem[int'(v.pic) * PIC_BYTES + b];
      if (inject && b == 5) begin
        in_valid  = 1'b1;
        in_pic_no = 4'd9;
      end
      tick();
      cyc++;
      in_valid = 1'b0;
      if (out_valid) early++;
    end
    rd_data_valid = 1'b0;
    rd_data       = 8'd0;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 8) begin
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        tick();
        cyc++;
        k++;
      end
    end
    chk("out_seen", seen, 1);
    chk("out_data", out_data, v.data);
    chk("latency", cyc, 19 + v.delay);
    chk("early_out", early, 0);
    tick();
    chk("out_pulse", out_valid, 0);
    chk("out_data_idle", out_data, 0);
    chk("idle_req", rd_req_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < PIC_CNT * PIC_BYTES; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < PIC_BYTES; i++) begin
      mem[0*PIC_BYTES + i]  = 8'h80;
      mem[1*PIC_BYTES + i]  = (i % 2 == 0) ? 8'h00 : 8'hFF;
      mem[2*PIC_BYTES + i]  = 8'(8 * i + 1);
      mem[3*PIC_BYTES + i]  = 8'd200;
      mem[15*PIC_BYTES + i] = 8'(16 * i);
    end

    vecs[0]  = '{4'd0,  1'b0, 2'd2, 0, 16'h0000, 8'h80};
    vecs[1]  = '{4'd0,  1'b0, 2'd3, 0, 16'h0000, 8'hFF};
    vecs[2]  = '{4'd0,  1'b0, 2'd0, 0, 16'h0000, 8'h20};
    vecs[3]  = '{4'd1,  1'b1, 2'd0, 0, 16'h0010, 8'hEF};
    vecs[4]  = '{4'd15, 1'b0, 2'd2, 5, 16'h00F0, 8'h78};
    vecs[5]  = '{4'd2,  1'b1, 2'd0, 0, 16'h0020, 8'h07};
    vecs[6]  = '{4'd2,  1'b0, 2'd3, 0, 16'h0020, 8'h7A};
    vecs[7]  = '{4'd3,  1'b0, 2'd3, 0, 16'h0030, 8'hFF};
    vecs[8]  = '{4'd3,  1'b0, 2'd1, 2, 16'h0030, 8'h64};
    vecs[9]  = '{4'd1,  1'b0, 2'd2, 0, 16'h0010, 8'h7F};
    vecs[10] = '{4'd0,  1'b1, 2'd1, 0, 16'h0000, 8'h00};
    vecs[11] = '{4'd15, 1'b1, 2'd0, 1, 16'h00F0, 8'h0F};

    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_pic_no     = 4'd0;
    in_mode       = 1'b0;
    in_ratio_mode = 2'd0;
    rd_req_ready  = 1'b0;
    rd_data_valid = 1'b0;
    rd_data       = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", rd_req_valid, 0);
    chk("rst_req_addr", rd_req_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0);

    // Stray in_valid mid-burst, then a command in the cycle right after out_valid.
    v_tmp = '{4'd2, 1'b0, 2'd2, 0, 16'h0020, 8'h3D};
    run_vec(v_tmp, 1'b1);
    v_tmp = '{4'd3, 1'b1, 2'd0, 0, 16'h0030, 8'h00};
    run_vec(v_tmp, 1'b0);

    // Reset in the middle of a burst abandons it.
    in_valid      = 1'b1;
    in_pic_no     = 4'd15;
    in_mode       = 1'b0;
    in_ratio_mode = 2'd3;
    tick();
    in_valid     = 1'b0;
    rd_req_ready = 1'b1;
    tick();
    rd_req_ready = 1'b0;
    for (int b = 0; b < 7; b++) begin
      rd_data_valid = 1'b1;
      rd_data       = mem[15*PIC_BYTES + b];
      tick();
    end
    rd_data = mem[15*PIC_BYTES + 7];
    rst_n   = 1'b0;
    #1;
    chk("arst_req_valid", rd_req_valid, 0);
    chk("arst_req_addr", rd_req_addr, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    rd_data_valid = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (out_valid) pulses++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (out_valid || rd_req_valid) pulses++;
      end
      chk("arst_no_out", pulses, 0);
    end
    v_tmp = '{4'd15, 1'b0, 2'd3, 0, 16'h00F0, 8'hB7};
    run_vec(v_tmp, 1'b0);

`ifdef PIC_STAT_CACHE_EN
    run_vec(vecs[0], 1'b0);
    begin
      int cyc;
      bit req_seen;
      bit seen;
      in_valid      = 1'b1;
      in_pic_no     = 4'd0;
      in_mode       = 1'b0;
      in_ratio_mode = 2'd2;
      tick();
      in_valid = 1'b0;
      cyc      = 1;
      req_seen = 1'b0;
      seen     = 1'b0;
      while (!seen && cyc < 8) begin
        if (rd_req_valid) req_seen = 1'b1;
        if (out_valid) begin
          seen = 1'b1;
        end else begin
          tick();
          cyc++;
        end
      end
      chk("hit_seen", seen, 1);
      chk("hit_latency", cyc, 2);
      chk("hit_no_req", req_seen, 0);
      chk("hit_data", out_data, 8'h80);
      tick();
      chk("hit_pulse", out_valid, 0);
    end
    v_tmp = '{4'd0, 1'b0, 2'd1, 0, 16'h0000, 8'h40};
    run_vec(v_tmp, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pic_stat_engine.md
Name: pic_stat_engine

Overview:
Command-driven picture statistics engine, the design-under-test stage directly fed by the image testbench stimulus (in_valid / in_pic_no / in_mode / in_ratio_mode).
- Per accepted command: fetches one picture from DRAM over a simple read-burst channel.
- Computes a single 8-bit statistic: exposure-scaled mean (mode 0) or adjacent-pixel contrast (mode 1).
- Returns the result as a one-cycle out_valid / out_data pulse.

Parameters:
- PIC_BYTES, 16: bytes per picture; power of two, at least 2; LOG2 derived internally.
- PIC_CNT, 16: number of pictures; in_pic_no range 0 to PIC_CNT-1.
- ADDR_W, 16: DRAM byte-address width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: command strobe, one cycle per command.
- in_pic_no, input, 4: picture index.
- in_mode, input, 1: 0 = exposure mean, 1 = contrast.
- in_ratio_mode, input, 2: exposure ratio; ignored in mode 1.
- rd_req_valid, output, 1: DRAM read-burst request.
- rd_req_ready, input, 1: DRAM accepts request.
- rd_req_addr, output, ADDR_W: burst start byte address.
- rd_data_valid, input, 1: one pixel beat.
- rd_data, input, 8: pixel byte.
- out_valid, output, 1: result strobe.
- out_data, output, 8: result; 0 whenever out_valid is 0.

Behaviour:
- Reset values: rd_req_valid 0, rd_req_addr 0, out_valid 0, out_data 0, FSM in IDLE, accumulator, beat counter and previous-pixel register all 0.
- FSM states and transitions:
  - IDLE -> REQ when in_valid=1. Latch pic_no, mode and ratio on that edge.
  - REQ: rd_req_valid=1, rd_req_addr = pic_no*PIC_BYTES. Address and valid are held stable until rd_req_ready=1. REQ -> RECV on the cycle where valid and ready are both 1.
  - RECV: each rd_data_valid beat is processed in its own cycle. Beat counter runs 0 to PIC_BYTES-1. RECV -> DONE on the beat where counter = PIC_BYTES-1.
  - DONE: out_valid=1 for exactly one cycle with the registered result, then IDLE.
- in_valid while not in IDLE is ignored; no queueing.
- A new command is accepted on the cycle after out_valid.
- rd_data_valid outside RECV is ignored.
- Mode 0, scaled pixel s by ratio:
  - 0: p>>2
  - 1: p>>1
  - 2: p
  - 3: min(p<<1, 255), saturating
  - Accumulator width 8+LOG2(PIC_BYTES); accumulate s over all beats.
- Mode 1: accumulate |p[i]-p[i-1]| for i = 1 to PIC_BYTES-1; beat 0 only loads the previous-pixel register.
- Result = accumulator >> LOG2(PIC_BYTES), floor. It is always at most 255; no further saturation.
- Minimum latency, in_valid to out_valid, with ready=1 and back-to-back data: PIC_BYTES+3 cycles.
- Reset asserted in any state returns the FSM to IDLE immediately. The pending burst is abandoned, with no out_valid. The DRAM side must tolerate the dropped burst.

Optional Feature:
PIC_STAT_CACHE_EN
- Defined:
  - Adds a PIC_CNT-entry result cache indexed by pic_no; each entry holds a valid bit plus {mode, ratio} tag plus 8-bit result.
  - Hit on accept (valid and tag match): skip REQ/RECV, go to DONE, so out_valid comes 2 cycles after in_valid, with no rd_req_valid.
  - Miss: normal flow, and the entry is written at DONE.
  - Reset clears all valid bits.
- Undefined: no cache storage; every command fetches from DRAM.

Decomposition:
- Package pic_stat_pkg holds:
  - state enum {IDLE, REQ, RECV, DONE};
  - ratio encoding constants;
  - mode constants;
  - pure function scale_pix(p, ratio).
- Natural sub-module: pic_stat_acc. It contains the accumulator, previous-pixel register, beat counter and last-beat flag, with clear/enable inputs driven by the FSM.

Test Plan:
- Pic 0 all 0x80, mode 0, ratio 2 -> rd_req_addr 0x0000, one out_valid pulse, out_data 0x80; ratio 3 -> 0xFF; ratio 0 -> 0x20.
- Pic 1 alternating 0x00/0xFF, mode 1 -> rd_req_addr 0x0010, out_data 0xEF (15*255 = 3825, >>4 = 239).
- Pic 15, rd_req_ready held low for 5 cycles -> rd_req_valid and rd_req_addr = 0x00F0 held stable throughout; result correct after the handshake.
- in_valid pulsed again during RECV -> ignored; exactly one out_valid; the next command is accepted on the cycle after out_valid.
- rst_n asserted on beat 7 of RECV -> all outputs 0 immediately, no out_valid; a subsequent command completes correctly.
- With PIC_STAT_CACHE_EN: repeat the pic 0 / mode 0 / ratio 2 command -> no rd_req_valid, out_valid 2 cycles after in_valid, out_data 0x80; same picture with ratio 1 -> miss, DRAM fetch issued.
